// File: rtl/tlb_pkg.sv
// Shared encodings, ELO field positions and helpers for the TLB management sequencer.
package tlb_pkg;

    typedef enum logic [2:0] {
        TLBOP_SRCH = 3'd0,
        TLBOP_RD   = 3'd1,
        TLBOP_WR   = 3'd2,
        TLBOP_FILL = 3'd3,
        TLBOP_INV  = 3'd4
    } tlb_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } tlb_state_e;

    localparam int ELO_V   = 0;
    localparam int ELO_D   = 1;
    localparam int ELO_PLV = 2;
    localparam int ELO_MAT = 4;
    localparam int ELO_G   = 6;
    localparam int ELO_PPN = 8;

    localparam logic [5:0] PS_4KB        = 6'd12;
    localparam logic [5:0] PS_4MB        = 6'd22;
    localparam logic [5:0] ECODE_TLBR    = 6'h3F;
    localparam logic [4:0] INVTLB_OP_MAX = 5'd6;

    function automatic logic [31:0] pack_elo(input logic [19:0] ppn, input logic g,
                                             input logic [1:0] mat, input logic [1:0] plv,
                                             input logic d, input logic v);
        logic [31:0] elo;
        elo                  = '0;
        elo[ELO_V]           = v;
        elo[ELO_D]           = d;
        elo[ELO_PLV +: 2]    = plv;
        elo[ELO_MAT +: 2]    = mat;
        elo[ELO_G]           = g;
        elo[ELO_PPN +: 20]   = ppn;
        return elo;
    endfunction

endpackage

// File: rtl/tlb_fill_idx.sv
// TLBFILL victim index generator: round-robin counter by default,
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) when TLB_FILL_LFSR_EN is defined.
module tlb_fill_idx
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adv,
    output logic [IW-1:0] idx
);

`ifdef TLB_FILL_LFSR_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 8'h01;
        end else if (adv) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign idx = lfsr[IW-1:0];
`else
    logic [IW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= (cnt == IW'(TLBNUM - 1)) ? '0 : cnt + 1'b1;
        end
    end

    assign idx = cnt;
`endif

endmodule

// File: rtl/tlb_ctrl.sv
// TLB management sequencer: runs TLBSRCH/RD/WR/FILL/INVTLB as IDLE -> EXEC -> DONE.
// Fill index source is chosen in tlb_fill_idx by TLB_FILL_LFSR_EN.
module tlb_ctrl
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [2:0]    op,
    input  logic [4:0]    inv_op,
    input  logic [9:0]    inv_asid,
    input  logic [18:0]   inv_vppn,
    input  logic [IW-1:0] csr_index,
    input  logic [5:0]    csr_ps,
    input  logic          csr_ne,
    input  logic [18:0]   csr_vppn,
    input  logic [9:0]    csr_asid,
    input  logic [31:0]   csr_elo0,
    input  logic [31:0]   csr_elo1,
    input  logic          csr_ecode_tlbr,
    output logic          s1_own,
    output logic [18:0]   s1_vppn_o,
    output logic [9:0]    s1_asid_o,
    input  logic          s1_found,
    input  logic [IW-1:0] s1_index,
    output logic          we,
    output logic [IW-1:0] w_index,
    output logic          w_e,
    output logic [18:0]   w_vppn,
    output logic [5:0]    w_ps,
    output logic [9:0]    w_asid,
    output logic          w_g,
    output logic [19:0]   w_ppn0,
    output logic [19:0]   w_ppn1,
    output logic [1:0]    w_plv0,
    output logic [1:0]    w_plv1,
    output logic [1:0]    w_mat0,
    output logic [1:0]    w_mat1,
    output logic          w_d0,
    output logic          w_d1,
    output logic          w_v0,
    output logic          w_v1,
    output logic [IW-1:0] r_index,
    input  logic          r_e,
    input  logic [18:0]   r_vppn,
    input  logic [5:0]    r_ps,
    input  logic [9:0]    r_asid,
    input  logic          r_g,
    input  logic [19:0]   r_ppn0,
    input  logic [19:0]   r_ppn1,
    input  logic [1:0]    r_plv0,
    input  logic [1:0]    r_plv1,
    input  logic [1:0]    r_mat0,
    input  logic [1:0]    r_mat1,
    input  logic          r_d0,
    input  logic          r_d1,
    input  logic          r_v0,
    input  logic          r_v1,
    output logic          invtlb_valid,
    output logic [4:0]    invtlb_op,
    output logic          done,
    output logic          err,
    output logic          wb_index_we,
    output logic [IW-1:0] wb_index,
    output logic          wb_ne,
    output logic          wb_entry_we,
    output logic [5:0]    wb_ps,
    output logic [18:0]   wb_vppn,
    output logic [31:0]   wb_elo0,
    output logic [31:0]   wb_elo1,
    output logic [9:0]    wb_asid
);

    tlb_state_e    state, state_nx;
    logic          accept, fill_adv, inv_legal;
    logic [IW-1:0] fill_idx;

    logic [2:0]    op_q;
    logic [4:0]    inv_op_q;
    logic [9:0]    inv_asid_q;
    logic [18:0]   inv_vppn_q;
    logic [IW-1:0] index_q;
    logic [5:0]    ps_q;
    logic          ne_q;
    logic [18:0]   vppn_q;
    logic [9:0]    asid_q;
    logic [31:0]   elo0_q, elo1_q;
    logic          ecode_q;
    logic          unused_elo;

    assign op_ready  = (state == ST_IDLE);
    assign accept    = op_valid && op_ready;
    assign inv_legal = (inv_op_q <= INVTLB_OP_MAX);

    // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx     = state;
        s1_own       = 1'b0;
        we           = 1'b0;
        invtlb_valid = 1'b0;
        fill_adv     = 1'b0;
        unique case (state)
            ST_IDLE: if (accept) state_nx = ST_EXEC;
            ST_EXEC: begin
                state_nx = ST_DONE;
                case (op_q)
                    TLBOP_SRCH: s1_own = 1'b1;
                    TLBOP_WR:   we = 1'b1;
                    TLBOP_FILL: begin
                        we       = 1'b1;
                        fill_adv = 1'b1;
                    end
                    TLBOP_INV: begin
                        s1_own       = 1'b1;
                        invtlb_valid = inv_legal;
                    end
                    default: ;
                endcase
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // NOTE: request registers are pure data rewritten at every accept, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q       <= op;
            inv_op_q   <= inv_op;
            inv_asid_q <= inv_asid;
            inv_vppn_q <= inv_vppn;
            index_q    <= csr_index;
            ps_q       <= csr_ps;
            ne_q       <= csr_ne;
            vppn_q     <= csr_vppn;
            asid_q     <= csr_asid;
            elo0_q     <= csr_elo0;
            elo1_q     <= csr_elo1;
            ecode_q    <= csr_ecode_tlbr;
        end
    end

    tlb_fill_idx #(.TLBNUM(TLBNUM)) u_fill_idx (
        .clk   (clk),
        .reset (reset),
        .adv   (fill_adv),
        .idx   (fill_idx)
    );

    assign s1_vppn_o = (op_q == TLBOP_INV) ? inv_vppn_q : vppn_q;
    assign s1_asid_o = (op_q == TLBOP_INV) ? inv_asid_q : asid_q;
    assign invtlb_op = inv_op_q;
    assign r_index   = index_q;

    // Entry is valid if it is the refill handler writing, or software cleared NE.
    assign w_index = (op_q == TLBOP_FILL) ? fill_idx : index_q;
    assign w_e     = ecode_q | ~ne_q;
    assign w_vppn  = vppn_q;
    assign w_ps    = ps_q;
    assign w_asid  = asid_q;
    assign w_g     = elo0_q[ELO_G] & elo1_q[ELO_G];
    assign w_ppn0  = elo0_q[ELO_PPN +: 20];
    assign w_ppn1  = elo1_q[ELO_PPN +: 20];
    assign w_plv0  = elo0_q[ELO_PLV +: 2];
    assign w_plv1  = elo1_q[ELO_PLV +: 2];
    assign w_mat0  = elo0_q[ELO_MAT +: 2];
    assign w_mat1  = elo1_q[ELO_MAT +: 2];
    assign w_d0    = elo0_q[ELO_D];
    assign w_d1    = elo1_q[ELO_D];
    assign w_v0    = elo0_q[ELO_V];
    assign w_v1    = elo1_q[ELO_V];

    assign unused_elo = ^{elo0_q[31:28], elo0_q[7], elo1_q[31:28], elo1_q[7]};

    // Completion results are captured on the EXEC edge and presented during DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            done        <= 1'b0;
            err         <= 1'b0;
            wb_index_we <= 1'b0;
            wb_entry_we <= 1'b0;
            wb_index    <= '0;
            wb_ne       <= 1'b0;
            wb_ps       <= '0;
            wb_vppn     <= '0;
            wb_elo0     <= '0;
            wb_elo1     <= '0;
            wb_asid     <= '0;
        end else begin
            done        <= 1'b0;
            err         <= 1'b0;
            wb_index_we <= 1'b0;
            wb_entry_we <= 1'b0;
            if (state == ST_EXEC) begin
                done <= 1'b1;
                case (op_q)
                    TLBOP_SRCH: begin
                        wb_index_we <= s1_found;
                        wb_ne       <= ~s1_found;
                        if (s1_found) wb_index <= s1_index;
                    end
                    TLBOP_RD: begin
                        wb_entry_we <= 1'b1;
                        wb_ne       <= ~r_e;
                        wb_ps       <= r_e ? r_ps   : '0;
                        wb_vppn     <= r_e ? r_vppn : '0;
                        wb_asid     <= r_e ? r_asid : '0;
                        wb_elo0     <= r_e ? pack_elo(r_ppn0, r_g, r_mat0, r_plv0, r_d0, r_v0) : '0;
                        wb_elo1     <= r_e ? pack_elo(r_ppn1, r_g, r_mat1, r_plv1, r_d1, r_v1) : '0;
                    end
                    TLBOP_WR, TLBOP_FILL: ;
                    TLBOP_INV: err <= ~inv_legal;
                    default:   err <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Self-checking bench for tlb_ctrl with a behavioural 16-entry TLB model on its ports.
// Fill-index expectations follow the TLB_FILL_LFSR_EN build selection.
module tb_tlb_ctrl;
    localparam int TLBNUM = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid, op_ready;
    logic [2:0]  op;
    logic [4:0]  inv_op;
    logic [9:0]  inv_asid, csr_asid, s1_asid_o, w_asid, r_asid, wb_asid;
    logic [18:0] inv_vppn, csr_vppn, s1_vppn_o, w_vppn, r_vppn, wb_vppn;
    logic [3:0]  csr_index, s1_index, w_index, r_index, wb_index;
    logic [5:0]  csr_ps, w_ps, r_ps, wb_ps;
    logic        csr_ne, csr_ecode_tlbr;
    logic [31:0] csr_elo0, csr_elo1, wb_elo0, wb_elo1;
    logic        s1_own, s1_found, we, w_e, w_g, r_e, r_g;
    logic [19:0] w_ppn0, w_ppn1, r_ppn0, r_ppn1;
    logic [1:0]  w_plv0, w_plv1, w_mat0, w_mat1, r_plv0, r_plv1, r_mat0, r_mat1;
    logic        w_d0, w_d1, w_v0, w_v1, r_d0, r_d1, r_v0, r_v1;
    logic        invtlb_valid, done, err, wb_index_we, wb_ne, wb_entry_we;
    logic [4:0]  invtlb_op;

    tlb_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op(op),
        .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
        .csr_index(csr_index), .csr_ps(csr_ps), .csr_ne(csr_ne), .csr_vppn(csr_vppn),
        .csr_asid(csr_asid), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1), .csr_ecode_tlbr(csr_ecode_tlbr),
        .s1_own(s1_own), .s1_vppn_o(s1_vppn_o), .s1_asid_o(s1_asid_o), .s1_found(s1_found), .s1_index(s1_index),
        .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps), .w_asid(w_asid), .w_g(w_g),
        .w_ppn0(w_ppn0), .w_ppn1(w_ppn1), .w_plv0(w_plv0), .w_plv1(w_plv1), .w_mat0(w_mat0), .w_mat1(w_mat1),
        .w_d0(w_d0), .w_d1(w_d1), .w_v0(w_v0), .w_v1(w_v1),
        .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
        .r_ppn0(r_ppn0), .r_ppn1(r_ppn1), .r_plv0(r_plv0), .r_plv1(r_plv1), .r_mat0(r_mat0), .r_mat1(r_mat1),
        .r_d0(r_d0), .r_d1(r_d1), .r_v0(r_v0), .r_v1(r_v1),
        .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .done(done), .err(err),
        .wb_index_we(wb_index_we), .wb_index(wb_index), .wb_ne(wb_ne), .wb_entry_we(wb_entry_we),
        .wb_ps(wb_ps), .wb_vppn(wb_vppn), .wb_elo0(wb_elo0), .wb_elo1(wb_elo1), .wb_asid(wb_asid)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural TLB ----------------
    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        logic [19:0] ppn0, ppn1;
        logic [1:0]  plv0, plv1, mat0, mat1;
        logic        d0, d1, v0, v1;
    } ent_t;

    ent_t mem [TLBNUM];

    initial for (int i = 0; i < TLBNUM; i++) mem[i] = '0;

    always_comb begin
        s1_found = 1'b0;
        s1_index = '0;
        for (int i = 0; i < TLBNUM; i++)
            if (mem[i].e && mem[i].vppn == s1_vppn_o && (mem[i].g || mem[i].asid == s1_asid_o)) begin
                s1_found = 1'b1;
                s1_index = 4'(i);
            end
    end

    assign r_e = mem[r_index].e;       assign r_vppn = mem[r_index].vppn;
    assign r_ps = mem[r_index].ps;     assign r_asid = mem[r_index].asid;
    assign r_g = mem[r_index].g;       assign r_ppn0 = mem[r_index].ppn0;
    assign r_ppn1 = mem[r_index].ppn1; assign r_plv0 = mem[r_index].plv0;
    assign r_plv1 = mem[r_index].plv1; assign r_mat0 = mem[r_index].mat0;
    assign r_mat1 = mem[r_index].mat1; assign r_d0 = mem[r_index].d0;
    assign r_d1 = mem[r_index].d1;     assign r_v0 = mem[r_index].v0;
    assign r_v1 = mem[r_index].v1;

    function automatic logic inv_hit(input ent_t en);
        logic am, vm;
        am = (en.asid == s1_asid_o);
        vm = (en.vppn == s1_vppn_o);
        case (invtlb_op)
            5'd0, 5'd1: return 1'b1;
            5'd2:       return en.g;
            5'd3:       return !en.g;
            5'd4:       return !en.g && am;
            5'd5:       return !en.g && am && vm;
            5'd6:       return (en.g || am) && vm;
            default:    return 1'b0;
        endcase
    endfunction

    int we_pulses = 0, done_pulses = 0;

    always @(posedge clk) begin
        if (we) begin
            mem[w_index] <= '{e: w_e, vppn: w_vppn, ps: w_ps, asid: w_asid, g: w_g,
                              ppn0: w_ppn0, ppn1: w_ppn1, plv0: w_plv0, plv1: w_plv1,
                              mat0: w_mat0, mat1: w_mat1, d0: w_d0, d1: w_d1, v0: w_v0, v1: w_v1};
        end
        if (invtlb_valid) begin
            for (int i = 0; i < TLBNUM; i++)
                if (inv_hit(mem[i])) mem[i].e <= 1'b0;
        end
        if (we) we_pulses++;
        if (done) done_pulses++;
    end

    // ---------------- checking ----------------
    int n_checks = 0, n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [3:0]  idx;
        logic [18:0] vppn;
        logic [9:0]  asid;
        logic [5:0]  ps;
        logic        ne;
        logic [31:0] elo0, elo1;
        logic        ecode;
        logic [4:0]  inv_op;
        logic        x_we;
        logic [3:0]  x_windex;
        logic        x_w_e, x_inv, x_s1own, x_err;
        int          x_kind;   // 0 no CSR update, 1 search result, 2 read result
        logic        x_idx_we;
        logic [3:0]  x_idx;
        logic        x_ne;
        logic [5:0]  x_ps;
        logic [18:0] x_vppn;
        logic [9:0]  x_asid;
        logic [31:0] x_elo0, x_elo1;
    } vec_t;

    task automatic apply(input vec_t v);
        logic is_inv;
        is_inv = (v.op == 3'd4);
        @(negedge clk);
        check({v.name, "_ready"}, 32'(op_ready), 32'd1);
        op             = v.op;
        csr_index      = v.idx;
        csr_ps         = v.ps;
        csr_ne         = v.ne;
        csr_elo0       = v.elo0;
        csr_elo1       = v.elo1;
        csr_ecode_tlbr = v.ecode;
        inv_op         = v.inv_op;
        csr_vppn       = is_inv ? ~v.vppn : v.vppn;
        csr_asid       = is_inv ? ~v.asid : v.asid;
        inv_vppn       = is_inv ? v.vppn : ~v.vppn;
        inv_asid       = is_inv ? v.asid : ~v.asid;
        op_valid       = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        check({v.name, "_exec_we"}, 32'(we), 32'(v.x_we));
        check({v.name, "_exec_inv"}, 32'(invtlb_valid), 32'(v.x_inv));
        check({v.name, "_exec_s1own"}, 32'(s1_own), 32'(v.x_s1own));
        check({v.name, "_exec_done"}, 32'(done), 32'd0);
        if (v.x_we) begin
            check({v.name, "_w_index"}, 32'(w_index), 32'(v.x_windex));
            check({v.name, "_w_e"}, 32'(w_e), 32'(v.x_w_e));
            check({v.name, "_w_vppn"}, 32'(w_vppn), 32'(v.vppn));
        end
        if (v.x_inv) check({v.name, "_invtlb_op"}, 32'(invtlb_op), 32'(v.inv_op));
        if (v.x_s1own) begin
            check({v.name, "_s1_vppn"}, 32'(s1_vppn_o), 32'(v.vppn));
            check({v.name, "_s1_asid"}, 32'(s1_asid_o), 32'(v.asid));
        end
        @(posedge clk); #1;
        check({v.name, "_done"}, 32'(done), 32'd1);
        check({v.name, "_err"}, 32'(err), 32'(v.x_err));
        check({v.name, "_idx_we"}, 32'(wb_index_we), 32'(v.x_idx_we));
        check({v.name, "_entry_we"}, 32'(wb_entry_we), (v.x_kind == 2) ? 32'd1 : 32'd0);
        if (v.x_kind != 0) check({v.name, "_ne"}, 32'(wb_ne), 32'(v.x_ne));
        if (v.x_idx_we) check({v.name, "_idx"}, 32'(wb_index), 32'(v.x_idx));
        if (v.x_kind == 2) begin
            check({v.name, "_ps"}, 32'(wb_ps), 32'(v.x_ps));
            check({v.name, "_vppn"}, 32'(wb_vppn), 32'(v.x_vppn));
            check({v.name, "_asid"}, 32'(wb_asid), 32'(v.x_asid));
            check({v.name, "_elo0"}, wb_elo0, v.x_elo0);
            check({v.name, "_elo1"}, wb_elo1, v.x_elo1);
        end
        @(posedge clk); #1;
        check({v.name, "_done_clr"}, 32'(done), 32'd0);
    endtask

    // fill index reference
    int         fill_m = 0;
    logic [7:0] lfsr_m = 8'h01;

    function automatic logic [3:0] next_fill();
        logic [3:0] r;
`ifdef TLB_FILL_LFSR_EN
        r      = lfsr_m[3:0];
        lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`else
        r      = 4'(fill_m);
        fill_m = (fill_m + 1) % TLBNUM;
`endif
        return r;
    endfunction

    function automatic vec_t mk_fill(input int i, input logic [3:0] exp_idx);
        vec_t f;
        f = '{"fill", 3'd3, ~exp_idx, 19'h00100 + 19'(i), 10'h0, 6'd12, 1'b0, 32'h0000_0001, 32'h0, 1'b0, '0,
              1'b1, exp_idx, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, '0, 1'b0, '0, '0, '0, '0, '0};
        f.name = $sformatf("fill%0d", i);
        return f;
    endfunction

    vec_t vecs [17];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            name               op    idx    vppn      asid     ps     ne    elo0          elo1          ecode inv_op  we    windex w_e   inv   s1own err  kind idx_we idx   ne    ps     vppn      asid     elo0          elo1
        vecs[0]  = '{"wr3",            3'd2, 4'd3,  19'h00012, 10'h005, 6'd12, 1'b0, 32'h0001_0001, 32'h0,        1'b0, 5'd0, 1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 4'd0, 1'b0, 6'd0,  19'h0,    10'h0,   32'h0,         32'h0};
        vecs[1]  = '{"srch_hit",       3'd0, 4'd0,  19'h00012, 10'h005, 6'd0,  1'b0, 32'h0,         32'h0,        1'b0, 5'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 4'd3, 1'b0, 6'd0,  19'h0,    10'h0,   32'h0,         32'h0};
        vecs[2]  = '{"rd3",            3'd1, 4'd3,  19'h0,     10'h0,   6'd0,  1'b0, 32'h0,         32'h0,        1'b0, 5'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 4'd0, 1'b0, 6'd12, 19'h00012, 10'h005, 32'h0001_0001, 32'h0};
        vecs[3]  = '{"rd9_empty",      3'd1, 4'd9,  19'h0,     10'h0,   6'd0,  1'b0, 32'h0,         32'h0,        1'b0, 5'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 4'd0, 1'b1, 6'd0,  19'h0,    10'h0,   32'h0,         32'h0};
        vecs[4]  = '{"srch_miss",      3'd0, 4'd0,  19'h7FFFF, 10'h005, 6'd0,  1'b0, 32'h0,         32'h0,        1'b0, 5'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 4'd0, 1'b1, 6'd0,  19'h0,    10'h0,   32'h0,         32'h0};
        vecs[5]  = '{"wr9_tlbr",       3'd2, 4'd9,  19'h00345, 10'h007, 6'd22, 1'b1, 32'h0002_005F, 32'h0002_0140, 1'b1, 5'd0, 1'b1, 4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 4'd0, 1'b0, 6'd0,  19'h0,    10'h0,   32'h0,         32'h0};
        vecs[6]  = '{"rd9",            3'd1, 4'd9,  19'h0,     10'h0,   6'd0,  1'b0, 32'h0,         32'h0,        1'b0, 5'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 4'd0, 1'b0, 6'd22, 19'h00345, 10'h007, 32'h0002_005F, 32'h0002_0140};
        vecs[7]  = '{"wr10_ne",        3'd2, 4'd10, 19'h00055, 10'h001, 6'd12, 1'b1, 32'h0,         32'h0,        1'b0, 5'd0, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 4'd0, 1'b0, 6'd0,  19'h0,    10'h0,   32'h0,         32'h0};
        vecs[8]  = '{"rd10_invalid",   3'd1, 4'd10, 19'h0,     10'h0,   6'd0,  1'b0, 32'h0,         32'h0,        1'b0, 5'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 4'd0, 1'b1, 6'd0,  19'h0,    10'h0,   32'h0,         32'h0};
        vecs[9]  = '{"srch_global",    3'd0, 4'd0,  19'h00345, 10'h002, 6'd0,  1'b0, 32'h0,         32'h0,        1'b0, 5'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 4'd9, 1'b0, 6'd0,  19'h0,    10'h0,   32'h0,         32'h0};
        vecs[10] = '{"illegal6",       3'd6, 4'd0,  19'h0,     10'h0,   6'd0,  1'b0, 32'h0,         32'h0,        1'b0, 5'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 4'd0, 1'b0, 6'd0,  19'h0,    10'h0,   32'h0,         32'h0};
        vecs[11] = '{"inv5",           3'd4, 4'd0,  19'h00012, 10'h005, 6'd0,  1'b0, 32'h0,         32'h0,        1'b0, 5'd5, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 4'd0, 1'b0, 6'd0,  19'h0,    10'h0,   32'h0,         32'h0};
        vecs[12] = '{"srch_post_inv5", 3'd0, 4'd0,  19'h00012, 10'h005, 6'd0,  1'b0, 32'h0,         32'h0,        1'b0, 5'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 4'd0, 1'b1, 6'd0,  19'h0,    10'h0,   32'h0,         32'h0};
        vecs[13] = '{"inv9",           3'd4, 4'd0,  19'h00012, 10'h005, 6'd0,  1'b0, 32'h0,         32'h0,        1'b0, 5'd9, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd0, 1'b0, 6'd0,  19'h0,    10'h0,   32'h0,         32'h0};
        vecs[14] = '{"inv6",           3'd4, 4'd0,  19'h00345, 10'h000, 6'd0,  1'b0, 32'h0,         32'h0,        1'b0, 5'd6, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 4'd0, 1'b0, 6'd0,  19'h0,    10'h0,   32'h0,         32'h0};
        vecs[15] = '{"srch_post_inv6", 3'd0, 4'd0,  19'h00345, 10'h002, 6'd0,  1'b0, 32'h0,         32'h0,        1'b0, 5'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 4'd0, 1'b1, 6'd0,  19'h0,    10'h0,   32'h0,         32'h0};
        vecs[16] = '{"illegal7",       3'd7, 4'd0,  19'h0,     10'h0,   6'd0,  1'b0, 32'h0,         32'h0,        1'b0, 5'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 4'd0, 1'b0, 6'd0,  19'h0,    10'h0,   32'h0,         32'h0};

        reset = 1'b1; op_valid = 1'b0; op = '0; inv_op = '0; inv_asid = '0; inv_vppn = '0;
        csr_index = '0; csr_ps = '0; csr_ne = 1'b0; csr_vppn = '0; csr_asid = '0;
        csr_elo0 = '0; csr_elo1 = '0; csr_ecode_tlbr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_op_ready", 32'(op_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_invtlb", 32'(invtlb_valid), 32'd0);
        check("rst_s1_own", 32'(s1_own), 32'd0);
        check("rst_wb_flags", {28'd0, wb_index_we, wb_ne, wb_entry_we, 1'b0}, 32'd0);
        check("rst_wb_index", 32'(wb_index), 32'd0);
        check("rst_wb_elo0", wb_elo0, 32'd0);
        check("rst_wb_vppn_asid_ps", {wb_vppn, wb_asid[9:0], 3'd0}, 32'd0);
        check("rst_wb_ps", 32'(wb_ps), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) apply(vecs[i]);

        // Seventeen fills: index sequence wraps after TLBNUM fills.
        for (int i = 0; i < 17; i++) apply(mk_fill(i, next_fill()));

        // Reset during EXEC: the write still goes out, then no done pulse follows.
        @(negedge clk);
        op = 3'd2; csr_index = 4'd5; csr_ne = 1'b0; csr_ecode_tlbr = 1'b0; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rstexec_we_still_issued", 32'(we), 32'd1);
        @(posedge clk); #1;
        check("rstexec_done", 32'(done), 32'd0);
        check("rstexec_ready", 32'(op_ready), 32'd1);
        check("rstexec_we_clr", 32'(we), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        fill_m = 0;
        lfsr_m = 8'h01;
        apply(mk_fill(100, next_fill()));

        // Reset during DONE: done drops and the controller is idle next cycle.
        @(negedge clk);
        op = 3'd1; csr_index = 4'd2; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        check("rstdone_done_hi", 32'(done), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rstdone_done", 32'(done), 32'd0);
        check("rstdone_ready", 32'(op_ready), 32'd1);
        check("rstdone_entry_we", 32'(wb_entry_we), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // op_valid held through EXEC and DONE is accepted only once.
        begin
            int we0, done0;
            we0 = we_pulses;
            done0 = done_pulses;
            @(negedge clk);
            op = 3'd2; csr_index = 4'd6; op_valid = 1'b1;
            @(posedge clk); #1;
            check("hold_exec_ready", 32'(op_ready), 32'd0);
            @(posedge clk); #1;
            check("hold_done_ready", 32'(op_ready), 32'd0);
            check("hold_done", 32'(done), 32'd1);
            @(negedge clk);
            op_valid = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            check("hold_we_pulses", 32'(we_pulses - we0), 32'd1);
            check("hold_done_pulses", 32'(done_pulses - done0), 32'd1);
            check("hold_idle_ready", 32'(op_ready), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
